instr_fifo: RTL and testbench

Parametrised instruction FIFO between qspi_controller and instruction_decoder. It replaces the fixed chain of four data_buffer stages with one circular buffer of configurable width and depth. It adds occupancy and watermark status so flash fetch can be throttled ahead of full, plus a synchronous flush for frame restarts. It also reports a sticky underrun flag for display-starvation debug.

---
 rtl/instr_fifo.sv | 82 ++++++++
 tb/tb_instr_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fifo.sv
// Instruction FIFO between the QSPI controller and the instruction decoder.
// Circular buffer with first-word-fall-through reads, occupancy and watermark status, flush and a sticky underrun flag.
module instr_fifo #(
    parameter int WIDTH      = 18,
    parameter int DEPTH      = 4,
    parameter int AFULL_LVL  = 3,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       underrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             primed;
    logic             push;
    logic             pop;

    // Handshakes depend only on the registered count, so wr_ready never sees rd_ready.
    always_comb begin
        wr_ready     = (count != DEPTH_C);
        rd_valid     = (count != '0);
        rd_data      = mem[rd_ptr];
        almost_full  = (count >= AFULL_C);
        almost_empty = (count <= AEMPTY_C);
        push         = wr_valid && wr_ready;
        pop          = rd_valid && rd_ready;
        count_next   = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            primed   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (count_next >= AFULL_C)
                primed <= 1'b1;
            // Starvation only counts once the buffer has been filled to the watermark.
            if (primed && rd_ready && (count == '0))
                underrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_instr_fifo.sv
// Self-checking bench for instr_fifo: a vector table for fill/drain plus hand sequences for
// streaming, underrun, flush and reset corner cases.
module tb_instr_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [17:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [17:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [2:0]  count;
    logic        almost_full;
    logic        almost_empty;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        wv;
        logic [17:0] wd;
        logic        rr;
        int          cnt;
        logic        wr;
        logic        rv;
        logic [17:0] data;
        logic        af;
        logic        ae;
        logic        ur;
    } vec_t;

    vec_t vecs [17];
    logic [17:0] model_q [$];

    instr_fifo #(.WIDTH(18), .DEPTH(4), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic compareValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, lets the rising edge happen, and returns 1 time unit after it.
    task automatic applyStimulus(input logic r, input logic f, input logic wv,
                                 input logic [17:0] wd, input logic rr);
        rst      = r;
        flush    = f;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int cnt, input logic wr, input logic rv,
                               input logic [17:0] data, input logic af, input logic ae,
                               input logic ur);
        compareValue({name, ".count"}, int'(count), cnt);
        compareValue({name, ".wr_ready"}, int'(wr_ready), int'(wr));
        compareValue({name, ".rd_valid"}, int'(rd_valid), int'(rv));
        if (rv)
            compareValue({name, ".rd_data"}, int'(rd_data), int'(data));
        compareValue({name, ".almost_full"}, int'(almost_full), int'(af));
        compareValue({name, ".almost_empty"}, int'(almost_empty), int'(ae));
        compareValue({name, ".underrun"}, int'(underrun), int'(ur));
    endtask

    initial begin
        // Expected values are the state after the edge on which the inputs were applied.
        //          rst   flush wv    wd       rr    cnt wr    rv    data     af    ae    ur
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 18'h0,  1'b0, 0, 1'b1, 1'b0, 18'h0,  1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 18'h0,  1'b0, 0, 1'b1, 1'b0, 18'h0,  1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 18'h0,  1'b0, 0, 1'b1, 1'b0, 18'h0,  1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 18'h0,  1'b0, 0, 1'b1, 1'b0, 18'h0,  1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 18'h0,  1'b0, 0, 1'b1, 1'b0, 18'h0,  1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 18'h0,  1'b0, 0, 1'b1, 1'b0, 18'h0,  1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 18'h1,  1'b0, 1, 1'b1, 1'b1, 18'h1,  1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 18'h2,  1'b0, 2, 1'b1, 1'b1, 18'h1,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 18'h3,  1'b0, 3, 1'b1, 1'b1, 18'h1,  1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 18'h4,  1'b0, 4, 1'b0, 1'b1, 18'h1,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 18'h5,  1'b0, 4, 1'b0, 1'b1, 18'h1,  1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 18'h5,  1'b0, 4, 1'b0, 1'b1, 18'h1,  1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 18'h5,  1'b0, 4, 1'b0, 1'b1, 18'h1,  1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 18'h5,  1'b1, 3, 1'b1, 1'b1, 18'h2,  1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 18'h5,  1'b1, 3, 1'b1, 1'b1, 18'h3,  1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 18'h0,  1'b1, 2, 1'b1, 1'b1, 18'h4,  1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 18'h0,  1'b1, 1, 1'b1, 1'b1, 18'h5,  1'b0, 1'b1, 1'b0};

        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].wv, vecs[i].wd, vecs[i].rr);
            checkOutput($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].wr, vecs[i].rv,
                        vecs[i].data, vecs[i].af, vecs[i].ae, vecs[i].ur);
        end

        // Streaming at count 2: pointers wrap several times, order must be preserved.
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h6, 1'b0);
        checkOutput("stream_prime", 2, 1'b1, 1'b1, 18'h5, 1'b0, 1'b0, 1'b0);
        model_q = '{18'h5, 18'h6};
        for (int k = 0; k < 20; k++) begin
            compareValue($sformatf("stream%0d.count", k), int'(count), 2);
            compareValue($sformatf("stream%0d.rd_data", k), int'(rd_data), int'(model_q[0]));
            void'(model_q.pop_front());
            model_q.push_back(18'(7 + k));
            applyStimulus(1'b0, 1'b0, 1'b1, 18'(7 + k), 1'b1);
        end
        checkOutput("stream_end", 2, 1'b1, 1'b1, model_q[0], 1'b0, 1'b0, 1'b0);

        // Underrun: prime by filling to the watermark, drain, then keep requesting.
        applyStimulus(1'b0, 1'b1, 1'b0, 18'h0, 1'b0);
        checkOutput("ur_flush0", 0, 1'b1, 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h100, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h101, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h102, 1'b0);
        checkOutput("ur_fill", 3, 1'b1, 1'b1, 18'h100, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 1'b1);
        checkOutput("ur_drain2", 1, 1'b1, 1'b1, 18'h102, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 1'b1);
        checkOutput("ur_empty", 0, 1'b1, 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 1'b1);
        checkOutput("ur_set", 0, 1'b1, 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h103, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h104, 1'b0);
        checkOutput("ur_sticky", 2, 1'b1, 1'b1, 18'h103, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 18'h0, 1'b0);
        checkOutput("ur_flush", 0, 1'b1, 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 1'b1);
        checkOutput("ur_unprimed", 0, 1'b1, 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);

        // Flush with a simultaneous push and pop discards both.
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h200, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h201, 1'b0);
        checkOutput("fl_pre", 2, 1'b1, 1'b1, 18'h200, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; flush = 1'b1; wr_valid = 1'b1; wr_data = 18'h202; rd_ready = 1'b1;
        #1;
        compareValue("fl_cycle.wr_ready", int'(wr_ready), 1);
        compareValue("fl_cycle.rd_valid", int'(rd_valid), 1);
        @(posedge clk);
        #1;
        checkOutput("fl_post", 0, 1'b1, 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h203, 1'b0);
        checkOutput("fl_nextword", 1, 1'b1, 1'b1, 18'h203, 1'b0, 1'b1, 1'b0);

        // Reset mid-operation, with a push attempted on the same edge.
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h204, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h205, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 18'h206, 1'b0);
        checkOutput("rst_mid", 0, 1'b1, 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 1'b1);
        checkOutput("rst_unprimed", 0, 1'b1, 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'h207, 1'b0);
        checkOutput("rst_push", 1, 1'b1, 1'b1, 18'h207, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
